// File: rtl/dsd6_bus_arb_pkg.sv
// ============================================================================
//  Module      : dsd6_bus_arb_pkg
//  Description : Shared types and constants for the DSD6 two-master external
//                memory bus arbiter (state encodings, timeout data pattern,
//                timeout counter width).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dsd6_bus_arb_pkg;

    // Arbiter state encodings. Value 2'd3 is unused and recovers to idle.
    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_GNT0 = 2'd1,
        ARB_GNT1 = 2'd2
    } arb_state_t;

    // Read data returned to a master whose cycle was killed by the timeout.
    localparam logic [63:0] c_timeout_data = 64'hFFFF_FFFF_FFFF_FFFF;

    // Width of the wait-state counter (TIMEOUT is limited to 1..255).
    localparam int unsigned c_cnt_w = 8;

endpackage

`default_nettype wire

// File: rtl/dsd6_bus_timeout.sv
// ============================================================================
//  Module      : dsd6_bus_timeout
//  Description : Wait-state counter for the bus arbiter. Counts cycles in
//                which the granted master waits for memory acknowledge and
//                flags when the count has reached the configured limit.
//  Ports       : clk_i     - system clock
//                rst_i     - synchronous active-high reset
//                clr_i     - clear count (grant entry / cycle completion)
//                inc_i     - count one wait cycle
//                limit     - terminal count (1..255)
//                expired_o - count equals limit
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dsd6_bus_timeout
    import dsd6_bus_arb_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               clr_i,
    input  logic               inc_i,
    input  logic [c_cnt_w-1:0] limit,
    output logic               expired_o
);

    logic [c_cnt_w-1:0] r_count;

    // Clear has priority over increment. The count holds at the limit so it
    // can never wrap back below it while a master is still waiting.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_count <= '0;
        end else if (clr_i) begin
            r_count <= '0;
        end else if (inc_i && (r_count != limit)) begin
            r_count <= r_count + {{(c_cnt_w-1){1'b0}}, 1'b1};
        end
    end

    assign expired_o = (r_count == limit);

endmodule

`default_nettype wire

// File: rtl/dsd6_bus_arb.sv
// ============================================================================
//  Module      : dsd6_bus_arb
//  Description : Two-master round-robin arbiter for the DSD6 external memory
//                bus. Master 0 is the page-table walker, master 1 the
//                translated CPU port. Supports bus lock hold, combinational
//                forwarding of the granted master's cycle and forced
//                termination (all-ones data, err_o pulse) of hung cycles.
//  Ports       : clk_i, rst_i              - clock, sync active-high reset
//                m0_*/m1_* (_i)            - master cycle requests
//                m0_rdy_o/m0_dat_o, m1_... - completion and read data
//                va_o..dat_o               - forwarded bus cycle
//                rdy_i, dat_i              - memory acknowledge / read data
//                gnt_o                     - one-hot grant (00 = idle)
//                err_o                     - timeout termination pulse
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dsd6_bus_arb
    import dsd6_bus_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    // master 0
    input  logic        m0_va_i,
    input  logic        m0_lock_i,
    input  logic        m0_wr_i,
    input  logic [7:0]  m0_sel_i,
    input  logic [47:0] m0_adr_i,
    input  logic [63:0] m0_dat_i,
    output logic        m0_rdy_o,
    output logic [63:0] m0_dat_o,
    // master 1
    input  logic        m1_va_i,
    input  logic        m1_lock_i,
    input  logic        m1_wr_i,
    input  logic [7:0]  m1_sel_i,
    input  logic [47:0] m1_adr_i,
    input  logic [63:0] m1_dat_i,
    output logic        m1_rdy_o,
    output logic [63:0] m1_dat_o,
    // memory side
    output logic        va_o,
    output logic        lock_o,
    output logic        wr_o,
    output logic [7:0]  sel_o,
    output logic [47:0] adr_o,
    output logic [63:0] dat_o,
    input  logic        rdy_i,
    input  logic [63:0] dat_i,
    // status
    output logic [1:0]  gnt_o,
    output logic        err_o
);

    localparam logic [c_cnt_w-1:0] c_limit = c_cnt_w'(TIMEOUT);

    arb_state_t r_state;
    arb_state_t w_state_nxt;
    logic       r_last_gnt;     // 0: master 0 granted last, 1: master 1

    logic w_req0;
    logic w_req1;
    logic w_granted;
    logic w_cur_va;
    logic w_cur_lock;
    logic w_done;
    logic w_timeout;
    logic w_expired;
    logic w_cnt_clr;
    logic w_cnt_inc;

    // ------------------------------------------------------------------
    // Wait-state counter. Held clear while idle so every grant starts at 0.
    // ------------------------------------------------------------------
    assign w_cnt_clr = (r_state == ARB_IDLE) | w_done;
    assign w_cnt_inc = w_granted & w_cur_va & ~rdy_i & ~w_expired;

    dsd6_bus_timeout u_timeout (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clr_i     (w_cnt_clr),
        .inc_i     (w_cnt_inc),
        .limit     (c_limit),
        .expired_o (w_expired)
    );

    // ------------------------------------------------------------------
    // Current owner's request signals
    // ------------------------------------------------------------------
    always_comb begin
        w_req0     = m0_va_i | m0_lock_i;
        w_req1     = m1_va_i | m1_lock_i;
        w_granted  = 1'b0;
        w_cur_va   = 1'b0;
        w_cur_lock = 1'b0;
        case (r_state)
            ARB_GNT0: begin
                w_granted  = 1'b1;
                w_cur_va   = m0_va_i;
                w_cur_lock = m0_lock_i;
            end
            ARB_GNT1: begin
                w_granted  = 1'b1;
                w_cur_va   = m1_va_i;
                w_cur_lock = m1_lock_i;
            end
            default: ;
        endcase
    end

    // Memory acknowledge beats the timeout when both land in the same cycle.
    assign w_done    = w_granted & w_cur_va & rdy_i;
    assign w_timeout = w_granted & w_cur_va & ~rdy_i & w_expired;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= ARB_IDLE;
            r_last_gnt <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == ARB_IDLE) && (w_state_nxt != ARB_IDLE)) begin
                r_last_gnt <= (w_state_nxt == ARB_GNT1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ARB_IDLE: begin
                if (w_req0 && w_req1) begin
                    w_state_nxt = r_last_gnt ? ARB_GNT0 : ARB_GNT1;
                end else if (w_req0) begin
                    w_state_nxt = ARB_GNT0;
                end else if (w_req1) begin
                    w_state_nxt = ARB_GNT1;
                end
            end
            ARB_GNT0, ARB_GNT1: begin
                if (w_timeout) begin
                    // A killed cycle also releases any lock the master holds.
                    w_state_nxt = ARB_IDLE;
                end else if (w_done) begin
                    w_state_nxt = w_cur_lock ? r_state : ARB_IDLE;
                end else if (!w_cur_va && !w_cur_lock) begin
                    w_state_nxt = ARB_IDLE;
                end
            end
            default: w_state_nxt = ARB_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Forwarding / response muxes
    // ------------------------------------------------------------------
    always_comb begin
        va_o     = 1'b0;
        lock_o   = 1'b0;
        wr_o     = 1'b0;
        sel_o    = '0;
        adr_o    = '0;
        dat_o    = '0;
        m0_rdy_o = 1'b0;
        m0_dat_o = '0;
        m1_rdy_o = 1'b0;
        m1_dat_o = '0;
        gnt_o    = 2'b00;
        case (r_state)
            ARB_GNT0: begin
                va_o     = m0_va_i & ~w_timeout;
                lock_o   = m0_lock_i;
                wr_o     = m0_wr_i;
                sel_o    = m0_sel_i;
                adr_o    = m0_adr_i;
                dat_o    = m0_dat_i;
                m0_rdy_o = (rdy_i & m0_va_i) | w_timeout;
                m0_dat_o = w_timeout ? c_timeout_data : dat_i;
                gnt_o    = 2'b01;
            end
            ARB_GNT1: begin
                va_o     = m1_va_i & ~w_timeout;
                lock_o   = m1_lock_i;
                wr_o     = m1_wr_i;
                sel_o    = m1_sel_i;
                adr_o    = m1_adr_i;
                dat_o    = m1_dat_i;
                m1_rdy_o = (rdy_i & m1_va_i) | w_timeout;
                m1_dat_o = w_timeout ? c_timeout_data : dat_i;
                gnt_o    = 2'b10;
            end
            default: ;
        endcase
    end

    assign err_o = w_timeout;

endmodule

`default_nettype wire

// File: tb/tb_dsd6_bus_arb.sv
// ============================================================================
//  Module      : tb_dsd6_bus_arb
//  Description : Self-checking bench for dsd6_bus_arb (TIMEOUT = 4).
//                Each scenario queues per-cycle stimulus with its expected
//                observation, then replays it and compares cycle by cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_dsd6_bus_arb;

    localparam int unsigned TIMEOUT = 4;
    localparam logic [63:0] c_ones  = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_va, m0_lock, m0_wr;
    logic [7:0]  m0_sel;
    logic [47:0] m0_adr;
    logic [63:0] m0_dat;
    logic        m0_rdy;
    logic [63:0] m0_rdat;
    logic        m1_va, m1_lock, m1_wr;
    logic [7:0]  m1_sel;
    logic [47:0] m1_adr;
    logic [63:0] m1_dat;
    logic        m1_rdy;
    logic [63:0] m1_rdat;
    logic        va_o, lock_o, wr_o;
    logic [7:0]  sel_o;
    logic [47:0] adr_o;
    logic [63:0] dat_o;
    logic        rdy;
    logic [63:0] mdat;
    logic [1:0]  gnt_o;
    logic        err_o;

    always #5 clk = ~clk;

    dsd6_bus_arb #(.TIMEOUT(TIMEOUT)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .m0_va_i   (m0_va),
        .m0_lock_i (m0_lock),
        .m0_wr_i   (m0_wr),
        .m0_sel_i  (m0_sel),
        .m0_adr_i  (m0_adr),
        .m0_dat_i  (m0_dat),
        .m0_rdy_o  (m0_rdy),
        .m0_dat_o  (m0_rdat),
        .m1_va_i   (m1_va),
        .m1_lock_i (m1_lock),
        .m1_wr_i   (m1_wr),
        .m1_sel_i  (m1_sel),
        .m1_adr_i  (m1_adr),
        .m1_dat_i  (m1_dat),
        .m1_rdy_o  (m1_rdy),
        .m1_dat_o  (m1_rdat),
        .va_o      (va_o),
        .lock_o    (lock_o),
        .wr_o      (wr_o),
        .sel_o     (sel_o),
        .adr_o     (adr_o),
        .dat_o     (dat_o),
        .rdy_i     (rdy),
        .dat_i     (mdat),
        .gnt_o     (gnt_o),
        .err_o     (err_o)
    );

    typedef struct packed {
        logic rst, v0, l0, v1, l1, rdy;
    } stim_t;

    typedef struct packed {
        logic [1:0]  gnt;
        logic        va, lock, wr;
        logic [7:0]  sel;
        logic [47:0] adr;
        logic [63:0] dat;
        logic        r0;
        logic [63:0] d0;
        logic        r1;
        logic [63:0] d1;
        logic        err;
    } obs_t;

    stim_t stim_q[$];
    obs_t  exp_q[$];
    int    total = 0;
    int    bad   = 0;

    function automatic stim_t s(input logic r, input logic v0, input logic l0,
                                input logic v1, input logic l1, input logic rd);
        stim_t t;
        t.rst = r; t.v0 = v0; t.l0 = l0; t.v1 = v1; t.l1 = l1; t.rdy = rd;
        return t;
    endfunction

    function automatic obs_t e_idle();
        obs_t o = '0;
        return o;
    endfunction

    // Expected observation while master m owns the bus: the bus carries that
    // master's attributes, only its response port is active.
    function automatic obs_t e_g(input int m, input logic va, input logic lock,
                                 input logic r, input logic [63:0] d, input logic err);
        obs_t o = '0;
        o.gnt  = (m == 1) ? 2'b10 : 2'b01;
        o.va   = va;
        o.lock = lock;
        o.err  = err;
        if (m == 1) begin
            o.wr = m1_wr; o.sel = m1_sel; o.adr = m1_adr; o.dat = m1_dat;
            o.r1 = r;     o.d1  = d;
        end else begin
            o.wr = m0_wr; o.sel = m0_sel; o.adr = m0_adr; o.dat = m0_dat;
            o.r0 = r;     o.d0  = d;
        end
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.gnt = gnt_o;  o.va  = va_o;   o.lock = lock_o; o.wr = wr_o;
        o.sel = sel_o;  o.adr = adr_o;  o.dat  = dat_o;
        o.r0  = m0_rdy; o.d0  = m0_rdat;
        o.r1  = m1_rdy; o.d1  = m1_rdat;
        o.err = err_o;
        return o;
    endfunction

    task automatic add(input stim_t st, input obs_t ex);
        stim_q.push_back(st);
        exp_q.push_back(ex);
    endtask

    // Drive one cycle's inputs mid-low-phase and settle before sampling.
    task automatic apply(input stim_t st);
        @(negedge clk);
        rst     = st.rst;
        m0_va   = st.v0;
        m0_lock = st.l0;
        m1_va   = st.v1;
        m1_lock = st.l1;
        rdy     = st.rdy;
        #1;
    endtask

    task automatic test_reset();
        int idx = 0;
        rst = 1'b1; m0_va = 1'b1; m0_lock = 1'b0; m1_va = 1'b1; m1_lock = 1'b0;
        rdy = 1'b1; mdat = 64'h1111_2222_3333_4444;
        m0_wr = 1'b1; m0_sel = 8'hFF; m0_adr = 48'hABC; m0_dat = 64'h5;
        m1_wr = 1'b1; m1_sel = 8'hFF; m1_adr = 48'hDEF; m1_dat = 64'h6;
        repeat (2) @(posedge clk);
        add(s(1, 1, 0, 1, 0, 1), e_idle());
        add(s(0, 0, 0, 0, 0, 0), e_idle());
        while (stim_q.size() > 0) begin
            obs_t got, want;
            apply(stim_q.pop_front());
            got  = sample();
            want = exp_q.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL reset[%0d] got=%h want=%h", idx, got, want);
            end
            idx++;
        end
    endtask

    task automatic test_single();
        int idx = 0;
        m0_wr = 1'b1; m0_sel = 8'hF0; m0_adr = 48'h1000; m0_dat = 64'hA5A5_5A5A_0F0F_F0F0;
        mdat  = 64'h0123_4567_89AB_CDEF;
        add(s(0, 1, 0, 0, 0, 1), e_idle());
        add(s(0, 1, 0, 0, 0, 1), e_g(0, 1, 0, 1, mdat, 0));
        add(s(0, 1, 0, 0, 0, 1), e_idle());
        add(s(0, 1, 0, 0, 0, 1), e_g(0, 1, 0, 1, mdat, 0));
        add(s(0, 0, 0, 0, 0, 1), e_idle());
        while (stim_q.size() > 0) begin
            obs_t got, want;
            apply(stim_q.pop_front());
            got  = sample();
            want = exp_q.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL single[%0d] got=%h want=%h", idx, got, want);
            end
            idx++;
        end
    endtask

    task automatic test_alternate();
        int idx = 0;
        m1_wr = 1'b0; m1_sel = 8'h0F; m1_adr = 48'h2000_0000_0040; m1_dat = 64'hCAFE_F00D_1234_5678;
        mdat  = 64'h7766_5544_3322_1100;
        // Reset first so the round-robin pointer starts from its reset value.
        add(s(1, 1, 0, 1, 0, 1), e_idle());
        for (int i = 0; i < 2; i++) begin
            add(s(0, 1, 0, 1, 0, 1), e_idle());
            add(s(0, 1, 0, 1, 0, 1), e_g(0, 1, 0, 1, mdat, 0));
            add(s(0, 1, 0, 1, 0, 1), e_idle());
            add(s(0, 1, 0, 1, 0, 1), e_g(1, 1, 0, 1, mdat, 0));
        end
        add(s(0, 0, 0, 0, 0, 1), e_idle());
        while (stim_q.size() > 0) begin
            obs_t got, want;
            apply(stim_q.pop_front());
            got  = sample();
            want = exp_q.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL alternate[%0d] got=%h want=%h", idx, got, want);
            end
            idx++;
        end
    endtask

    task automatic test_lock();
        int idx = 0;
        mdat = 64'h0BAD_F00D_0000_0001;
        add(s(0, 0, 0, 1, 1, 0), e_idle());
        add(s(0, 1, 0, 1, 1, 1), e_g(1, 1, 1, 1, mdat, 0));
        add(s(0, 1, 0, 0, 1, 1), e_g(1, 0, 1, 0, mdat, 0));
        add(s(0, 1, 0, 1, 1, 1), e_g(1, 1, 1, 1, mdat, 0));
        add(s(0, 1, 0, 0, 0, 1), e_g(1, 0, 0, 0, mdat, 0));
        add(s(0, 1, 0, 0, 0, 1), e_idle());
        add(s(0, 1, 0, 0, 0, 1), e_g(0, 1, 0, 1, mdat, 0));
        add(s(0, 0, 0, 0, 0, 1), e_idle());
        while (stim_q.size() > 0) begin
            obs_t got, want;
            apply(stim_q.pop_front());
            got  = sample();
            want = exp_q.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL lock[%0d] got=%h want=%h", idx, got, want);
            end
            idx++;
        end
    endtask

    task automatic test_timeout();
        int idx = 0;
        mdat = 64'h1234_0000_5678_0000;
        add(s(0, 1, 1, 0, 0, 0), e_idle());
        for (int i = 0; i < int'(TIMEOUT); i++) begin
            add(s(0, 1, 1, 0, 0, 0), e_g(0, 1, 1, 0, mdat, 0));
        end
        add(s(0, 1, 1, 0, 0, 0), e_g(0, 0, 1, 1, c_ones, 1));
        // Lock still asserted, yet the arbiter must have released the bus.
        add(s(0, 1, 1, 0, 0, 1), e_idle());
        add(s(0, 1, 1, 0, 0, 1), e_g(0, 1, 1, 1, mdat, 0));
        add(s(0, 0, 0, 0, 0, 0), e_g(0, 0, 0, 0, mdat, 0));
        add(s(0, 0, 0, 0, 0, 0), e_idle());
        while (stim_q.size() > 0) begin
            obs_t got, want;
            apply(stim_q.pop_front());
            got  = sample();
            want = exp_q.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL timeout[%0d] got=%h want=%h", idx, got, want);
            end
            idx++;
        end
    endtask

    task automatic test_timeout_race();
        int idx = 0;
        mdat = 64'hDEAD_BEEF_0000_1234;
        add(s(0, 0, 0, 1, 0, 0), e_idle());
        for (int i = 0; i < int'(TIMEOUT); i++) begin
            add(s(0, 0, 0, 1, 0, 0), e_g(1, 1, 0, 0, mdat, 0));
        end
        add(s(0, 0, 0, 1, 0, 1), e_g(1, 1, 0, 1, mdat, 0));
        add(s(0, 0, 0, 0, 0, 0), e_idle());
        while (stim_q.size() > 0) begin
            obs_t got, want;
            apply(stim_q.pop_front());
            got  = sample();
            want = exp_q.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL race[%0d] got=%h want=%h", idx, got, want);
            end
            idx++;
        end
    endtask

    task automatic test_reset_mid();
        int idx = 0;
        mdat = 64'h5555_AAAA_5555_AAAA;
        add(s(0, 0, 0, 1, 0, 0), e_idle());
        add(s(0, 0, 0, 1, 0, 0), e_g(1, 1, 0, 0, mdat, 0));
        add(s(1, 0, 0, 1, 0, 0), e_g(1, 1, 0, 0, mdat, 0));
        add(s(0, 1, 0, 1, 0, 1), e_idle());
        add(s(0, 1, 0, 1, 0, 1), e_g(0, 1, 0, 1, mdat, 0));
        add(s(0, 0, 0, 0, 0, 0), e_idle());
        while (stim_q.size() > 0) begin
            obs_t got, want;
            apply(stim_q.pop_front());
            got  = sample();
            want = exp_q.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL reset_mid[%0d] got=%h want=%h", idx, got, want);
            end
            idx++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_alternate();
        test_lock();
        test_timeout();
        test_timeout_race();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
